// File: rtl/temporizador.sv
// Countdown timer for the microwave controller: MM:SS BCD entry from the keypad,
// once-per-second countdown while the magnetron runs, registered tdone at zero.
module temporizador #(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digito,
    input  logic       digito_valido,
    input  logic       limpan,
    input  logic       m_on,
    output logic [3:0] min_dez,
    output logic [3:0] min_uni,
    output logic [3:0] seg_dez,
    output logic [3:0] seg_uni,
    output logic       tdone
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

    logic [3:0]    min_dez_q, min_dez_d;
    logic [3:0]    min_uni_q, min_uni_d;
    logic [3:0]    seg_dez_q, seg_dez_d;
    logic [3:0]    seg_uni_q, seg_uni_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tdone_q, tdone_d;
    logic          time_zero_s;

    assign time_zero_s = (min_dez_q == 4'd0) && (min_uni_q == 4'd0) &&
                         (seg_dez_q == 4'd0) && (seg_uni_q == 4'd0);

    // Next-state: clear > digit entry > countdown tick.
    always_comb begin
        min_dez_d = min_dez_q;
        min_uni_d = min_uni_q;
        seg_dez_d = seg_dez_q;
        seg_uni_d = seg_uni_q;
        presc_d   = presc_q;

        if (!limpan) begin
            min_dez_d = 4'd0;
            min_uni_d = 4'd0;
            seg_dez_d = 4'd0;
            seg_uni_d = 4'd0;
            presc_d   = PRESC_ZERO;
        end else if (digito_valido && !m_on && (digito <= 4'd9)) begin
            min_dez_d = min_uni_q;
            min_uni_d = seg_dez_q;
            seg_dez_d = seg_uni_q;
            seg_uni_d = digito;
        end else if (time_zero_s) begin
            // Parked at zero: no ticks, so the display can never wrap to 99:59.
            presc_d = PRESC_ZERO;
        end else if (m_on) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = PRESC_ZERO;
                if (seg_uni_q != 4'd0) begin
                    seg_uni_d = seg_uni_q - 4'd1;
                end else begin
                    seg_uni_d = 4'd9;
                    if (seg_dez_q != 4'd0) begin
                        seg_dez_d = seg_dez_q - 4'd1;
                    end else begin
                        seg_dez_d = 4'd5;
                        if (min_uni_q != 4'd0) begin
                            min_uni_d = min_uni_q - 4'd1;
                        end else begin
                            min_uni_d = 4'd9;
                            if (min_dez_q != 4'd0) begin
                                min_dez_d = min_dez_q - 4'd1;
                            end else begin
                                min_dez_d = min_dez_q;
                            end
                        end
                    end
                end
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end else begin
            presc_d = presc_q;
        end

        tdone_d = (min_dez_d == 4'd0) && (min_uni_d == 4'd0) &&
                  (seg_dez_d == 4'd0) && (seg_uni_d == 4'd0);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_dez_q <= 4'd0;
            min_uni_q <= 4'd0;
            seg_dez_q <= 4'd0;
            seg_uni_q <= 4'd0;
            presc_q   <= PRESC_ZERO;
            tdone_q   <= 1'b1;
        end else begin
            min_dez_q <= min_dez_d;
            min_uni_q <= min_uni_d;
            seg_dez_q <= seg_dez_d;
            seg_uni_q <= seg_uni_d;
            presc_q   <= presc_d;
            tdone_q   <= tdone_d;
        end
    end

    assign min_dez = min_dez_q;
    assign min_uni = min_uni_q;
    assign seg_dez = seg_dez_q;
    assign seg_uni = seg_uni_q;
    assign tdone   = tdone_q;

endmodule

// File: tb/tb_temporizador.sv
// Directed bench for temporizador with TICK_DIV=4: vector table for reset/entry,
// hand-written sequences for countdown, borrow, pause and priority corners.
module tb_temporizador;

    logic       clk;
    logic       rst;
    logic [3:0] digito;
    logic       digito_valido;
    logic       limpan;
    logic       m_on;
    logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
    logic       tdone;

    int errors;
    int checks;

    temporizador #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .digito(digito), .digito_valido(digito_valido),
        .limpan(limpan), .m_on(m_on), .min_dez(min_dez), .min_uni(min_uni),
        .seg_dez(seg_dez), .seg_uni(seg_uni), .tdone(tdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [3:0]  d;
        logic        dv;
        logic        lim;
        logic        mon;
        logic [15:0] exp_t;
        logic        exp_done;
    } vec_t;

    vec_t tbl[16];

    task automatic step(input logic r, input logic [3:0] d, input logic dv,
                        input logic lim, input logic mon);
        @(negedge clk);
        rst = r; digito = d; digito_valido = dv; limpan = lim; m_on = mon;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] exp_t, input logic exp_done);
        logic [15:0] got;
        got = {min_dez, min_uni, seg_dez, seg_uni};
        checks++;
        if (got !== exp_t || tdone !== exp_done) begin
            errors++;
            $display("FAIL %s: got %h tdone=%b, expected %h tdone=%b",
                     name, got, tdone, exp_t, exp_done);
        end
    endtask

    // Clear, then shift in four digits with the magnetron off.
    task automatic load(input logic [15:0] t);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, t[i*4 +: 4], 1'b1, 1'b1, 1'b0);
        end
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [15:0] e_t;
        errors = 0;
        checks = 0;
        rst = 1'b1; digito = 4'd0; digito_valido = 1'b0; limpan = 1'b1; m_on = 1'b0;

        //          r     d      dv    lim   mon   expected  tdone
        tbl[0]  = '{1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[1]  = '{1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[2]  = '{1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0};
        tbl[3]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0};
        tbl[4]  = '{1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 16'h0013, 1'b0};
        tbl[5]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0130, 1'b0};
        tbl[6]  = '{1'b0, 4'hC, 1'b1, 1'b1, 1'b0, 16'h0130, 1'b0};
        tbl[7]  = '{1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 16'h1305, 1'b0};
        tbl[8]  = '{1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 16'h3057, 1'b0};
        tbl[9]  = '{1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 16'h3057, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[11] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[12] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[13] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[14] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[15] = '{1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1};

        for (int i = 0; i < 2; i++) begin
            step(tbl[i].r, tbl[i].d, tbl[i].dv, tbl[i].lim, tbl[i].mon);
            chk($sformatf("vec%0d", i), tbl[i].exp_t, tbl[i].exp_done);
        end

        // After reset, running with zero time must stay parked at 00:00.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
            chk("idle_run_zero", 16'h0000, 1'b1);
        end

        for (int i = 2; i < 16; i++) begin
            step(tbl[i].r, tbl[i].d, tbl[i].dv, tbl[i].lim, tbl[i].mon);
            chk($sformatf("vec%0d", i), tbl[i].exp_t, tbl[i].exp_done);
        end

        // Countdown from 00:02: 00:01 at edge 4, 00:00 at edge 8, held to edge 40.
        load(16'h0002);
        for (int e = 1; e <= 40; e++) begin
            step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
            e_t = (e < 4) ? 16'h0002 : (e < 8) ? 16'h0001 : 16'h0000;
            chk($sformatf("countdown_e%0d", e), e_t, (e_t == 16'h0000));
        end

        // Borrow chains.
        load(16'h0100);
        for (int e = 0; e < 4; e++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("borrow_0100", 16'h0059, 1'b0);
        load(16'h1000);
        for (int e = 0; e < 4; e++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("borrow_1000", 16'h0959, 1'b0);
        load(16'h0075);
        for (int e = 0; e < 4; e++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("from75_1tick", 16'h0074, 1'b0);
        for (int e = 0; e < 56; e++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("from75_15ticks", 16'h0060, 1'b0);
        for (int e = 0; e < 4; e++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("from75_16ticks", 16'h0059, 1'b0);

        // Pause/resume keeps the partial second.
        load(16'h0005);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("pause_run2", 16'h0005, 1'b0);
        for (int e = 0; e < 10; e++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("pause_hold", 16'h0005, 1'b0);
        step(1'b0, 4'd7, 1'b1, 1'b1, 1'b0);
        chk("pause_entry", 16'h0057, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("resume_e1", 16'h0057, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("resume_e2", 16'h0056, 1'b0);

        // Clear beats digit and tick; prescaler must restart from 0.
        load(16'h0040);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("clr_pre", 16'h0040, 1'b0);
        step(1'b0, 4'd3, 1'b1, 1'b0, 1'b1);
        chk("clr_priority", 16'h0000, 1'b1);
        step(1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
        chk("clr_reload", 16'h0001, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
            e_t = (e < 4) ? 16'h0001 : 16'h0000;
            chk($sformatf("clr_presc_e%0d", e), e_t, (e_t == 16'h0000));
        end

        // Clear and tick on the same edge: clear wins.
        load(16'h0040);
        for (int e = 0; e < 3; e++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("clr_vs_tick", 16'h0000, 1'b1);

        // Reset mid-countdown.
        load(16'h0030);
        for (int e = 0; e < 6; e++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("rst_pre", 16'h0029, 1'b0);
        step(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("rst_mid", 16'h0000, 1'b1);

        // m_on toggling at zero changes nothing.
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 4'd0, 1'b0, 1'b1, e[0]);
            chk("toggle_zero", 16'h0000, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
